// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 7-segment driver for the board display.
//
// Takes NUM_FIELDS binary field values and scans NDIG = NUM_FIELDS*DIG_PER_FIELD
// digits with active-low segment and anode outputs. Each field is converted to
// BCD by a sequential double-dabble engine. The conversion works from a per-frame
// snapshot of the field values. Values of 10^DIG_PER_FIELD or more saturate to
// all 9s. Leading zeros can be blanked.
//
// Optional feature: define SEG_BLINK_EN to add the BLINK_FRAMES parameter and
// the blink_mask input. Digits whose mask bit is set go dark on alternate
// groups of BLINK_FRAMES frames.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   vals       in   field values, field f at [f*VAL_W +: VAL_W]
//   mode       in   0 numeric, 1 blank, 2 dash, 3 lamp test
//   dp_mask    in   per-digit decimal point enable (modes 0 and 2)
//   blink_mask in   per-digit blink enable (SEG_BLINK_EN only)
//   sig_c      out  segments, active low, {dp,g,f,e,d,c,b,a}
//   pos        out  digit anodes, active low, one-hot
//   frame_tick out  pulse on the last cycle of the last digit
//   conv_busy  out  BCD converter running
//
// Converter states:
//   state | meaning
//   IDLE  | waiting for a snapshot (reset release or frame_tick)
//   LOAD  | pick field fld from the snapshot, clear BCD, flag saturation
//   SHIFT | VAL_W double-dabble iterations
//   STORE | write the field's nibbles to the digit buffer, advance fld
module seg_scan_mux #(
  parameter int NUM_FIELDS    = 2,
  parameter int DIG_PER_FIELD = 2,
  parameter int VAL_W         = 7,
  parameter int SCAN_CYC      = 4000,
  parameter int LZ_BLANK      = 1
`ifdef SEG_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_FIELDS*VAL_W-1:0]           vals,
  input  logic [1:0]                            mode,
  input  logic [NUM_FIELDS*DIG_PER_FIELD-1:0]   dp_mask,
`ifdef SEG_BLINK_EN
  input  logic [NUM_FIELDS*DIG_PER_FIELD-1:0]   blink_mask,
`endif
  output logic [7:0]                            sig_c,
  output logic [NUM_FIELDS*DIG_PER_FIELD-1:0]   pos,
  output logic                                  frame_tick,
  output logic                                  conv_busy
);

  localparam int NDIG  = NUM_FIELDS * DIG_PER_FIELD;
  localparam int CW    = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int DW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FW    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int BW    = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int BCD_W = 4 * DIG_PER_FIELD;
  localparam logic [63:0] SAT_LIM = 64'(10 ** DIG_PER_FIELD);
  // Any nibble above 9 decodes to a dark digit; 0xF is the canonical blank.
  localparam logic [3:0] NIB_BLANK = 4'hF;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} conv_state_t;

  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_code = 8'h3F;
      4'd1:    seg_code = 8'h06;
      4'd2:    seg_code = 8'h5B;
      4'd3:    seg_code = 8'h4F;
      4'd4:    seg_code = 8'h66;
      4'd5:    seg_code = 8'h6D;
      4'd6:    seg_code = 8'h7D;
      4'd7:    seg_code = 8'h07;
      4'd8:    seg_code = 8'h7F;
      4'd9:    seg_code = 8'h6F;
      default: seg_code = 8'h00;
    endcase
  endfunction

  // ---------------- scan counters ----------------
  logic [CW-1:0] cyc_cnt;
  logic [DW-1:0] dig_idx;
  logic          cyc_last;
  logic          dig_last;

  assign cyc_last   = (cyc_cnt == CW'(SCAN_CYC - 1));
  assign dig_last   = (dig_idx == DW'(NDIG - 1));
  assign frame_tick = cyc_last && dig_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      dig_idx <= '0;
    end else if (cyc_last) begin
      cyc_cnt <= '0;
      dig_idx <= dig_last ? '0 : dig_idx + 1'b1;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  // ---------------- converter ----------------
  conv_state_t                 state;
  logic                        init_pend;
  logic [NUM_FIELDS*VAL_W-1:0] shadow;
  logic [FW-1:0]               fld;
  logic [BW-1:0]               bit_cnt;
  logic [VAL_W-1:0]            bin_sh;
  logic [BCD_W-1:0]            bcd;
  logic                        sat;
  logic [4*NDIG-1:0]           dig_buf;

  logic                        start;
  logic [VAL_W-1:0]            cur_val;
  logic [BCD_W-1:0]            bcd_adj;
  logic [BCD_W-1:0]            bcd_src;
  logic [BCD_W-1:0]            store_nib;
  logic                        lead;

  // init_pend makes the very first cycle after reset release start a conversion.
  assign start   = init_pend | frame_tick;
  assign cur_val = shadow[int'(fld)*VAL_W +: VAL_W];

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIG_PER_FIELD; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Nibbles to store for the current field: saturation first, then blank
  // the run of leading zeros while keeping the field's lowest digit.
  always_comb begin
    bcd_src   = sat ? {DIG_PER_FIELD{4'd9}} : bcd;
    store_nib = bcd_src;
    lead      = 1'b1;
    for (int d = DIG_PER_FIELD - 1; d >= 0; d--) begin
      lead = lead && (bcd_src[4*d +: 4] == 4'd0);
      if ((LZ_BLANK != 0) && (d > 0) && lead)
        store_nib[4*d +: 4] = NIB_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      conv_busy <= 1'b0;
      init_pend <= 1'b1;
      shadow    <= '0;
      fld       <= '0;
      bit_cnt   <= '0;
      bin_sh    <= '0;
      bcd       <= '0;
      sat       <= 1'b0;
      dig_buf   <= {NDIG{NIB_BLANK}};
    end else begin
      init_pend <= 1'b0;
      case (state)
        IDLE: begin
          // Only snapshot when idle, so a field can never be half old, half new.
          if (start) begin
            shadow    <= vals;
            fld       <= '0;
            state     <= LOAD;
            conv_busy <= 1'b1;
          end
        end
        LOAD: begin
          bin_sh  <= cur_val;
          bcd     <= '0;
          bit_cnt <= '0;
          sat     <= (64'(cur_val) >= SAT_LIM);
          state   <= SHIFT;
        end
        SHIFT: begin
          // Bits shifted out of the top only occur for saturated values.
          bcd     <= BCD_W'({bcd_adj, bin_sh[VAL_W-1]});
          bin_sh  <= bin_sh << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(VAL_W - 1))
            state <= STORE;
        end
        STORE: begin
          dig_buf[int'(fld)*BCD_W +: BCD_W] <= store_nib;
          if (fld == FW'(NUM_FIELDS - 1)) begin
            fld       <= '0;
            state     <= IDLE;
            conv_busy <= 1'b0;
          end else begin
            fld   <= fld + 1'b1;
            state <= LOAD;
          end
        end
        default: begin
          state     <= IDLE;
          conv_busy <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- optional blink ----------------
  logic dark;
`ifdef SEG_BLINK_EN
  localparam int FCW = $clog2(BLINK_FRAMES + 1);
  logic [FCW-1:0] frm_cnt;
  logic           blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (frm_cnt == FCW'(BLINK_FRAMES - 1)) begin
        frm_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  assign dark = blink_phase & blink_mask[dig_idx];
`else
  assign dark = 1'b0;
`endif

  // ---------------- output stage ----------------
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic [7:0] seg_on;

  always_comb begin
    cur_nib = dig_buf[int'(dig_idx)*4 +: 4];
    cur_dp  = dp_mask[dig_idx];
    case (mode)
      2'd0:    seg_on = seg_code(cur_nib) | {cur_dp, 7'h00};
      2'd1:    seg_on = 8'h00;
      2'd2:    seg_on = {cur_dp, 7'h40};
      default: seg_on = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_c <= 8'hFF;
      pos   <= '1;
    end else begin
      sig_c <= dark ? 8'hFF : ~seg_on;
      pos   <= ~(NDIG'(1) << dig_idx);
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed, self-checking bench for seg_scan_mux.
// Expected segment/anode values come from an arithmetic model (div/mod by 10),
// pushed to a scoreboard queue and popped when the DUT output is sampled.
// Defining SEG_BLINK_EN also exercises the blink feature with BLINK_FRAMES=2.
module tb_seg_scan_mux;
  localparam int SC = 20;  // scan cycles per digit; must exceed 2*(7+2)

  logic        clk;
  logic        rst_n;
  logic [13:0] vals;
  logic [1:0]  mode;
  logic [3:0]  dp_mask;
  logic [7:0]  sig_c;
  logic [3:0]  pos;
  logic        frame_tick;
  logic        conv_busy;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask;
`endif

  int n_err;
  int n_checks;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  seg_scan_mux #(
    .NUM_FIELDS(2), .DIG_PER_FIELD(2), .VAL_W(7), .SCAN_CYC(SC), .LZ_BLANK(1)
`ifdef SEG_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .vals(vals), .mode(mode), .dp_mask(dp_mask),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .sig_c(sig_c), .pos(pos), .frame_tick(frame_tick), .conv_busy(conv_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input int n);
    case (n)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
      8: return 8'h7F; 9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_sig(input logic [13:0] v, input int d,
                                         input logic [1:0] m, input logic [3:0] dp);
    int val, tens, ones, nib;
    bit blank;
    logic [7:0] hi;
    val = int'(v[(d/2)*7 +: 7]);
    if (val >= 100) begin
      tens = 9; ones = 9;
    end else begin
      tens = val / 10; ones = val % 10;
    end
    nib   = (d % 2 == 1) ? tens : ones;
    blank = (d % 2 == 1) && (tens == 0);
    case (m)
      2'd0:    hi = (blank ? 8'h00 : seg_of(nib)) | (dp[d] ? 8'h80 : 8'h00);
      2'd1:    hi = 8'h00;
      2'd2:    hi = 8'h40 | (dp[d] ? 8'h80 : 8'h00);
      default: hi = 8'hFF;
    endcase
    return ~hi;
  endfunction

  function automatic logic [7:0] exp_pos(input int d);
    logic [3:0] p;
    p = 4'b0001 << d;
    return {4'h0, ~p};
  endfunction

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    exp_t e;
    e = sb.pop_front();
    n_checks++;
    assert (obs === e.val) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    n_checks++;
    assert (seen === 1'b1) else begin
      n_err++;
      $error("FAIL frame_tick_timeout observed=%0b expected=1", seen);
    end
  endtask

  // Waits for a frame_tick, then samples every digit mid-way through its slot
  // in the following frame. Output for digit d is visible from tick+2+d*SC.
  task automatic check_frame(input logic [13:0] v, input logic [1:0] m,
                             input logic [3:0] dp, input string tag);
    int k;
    k = 0;
    wait_tick();
    for (int d = 0; d < 4; d++) begin
      push($sformatf("%s_d%0d_sig", tag, d), exp_sig(v, d, m, dp));
      push($sformatf("%s_d%0d_pos", tag, d), exp_pos(d));
      while (k < 2 + d*SC + SC/2) begin
        @(negedge clk);
        k++;
      end
      pop_check(sig_c);
      pop_check({4'h0, pos});
    end
  endtask

  initial begin
    int cnt;
    int k;
    n_err    = 0;
    n_checks = 0;
    rst_n    = 1'b1;
    vals     = {7'd7, 7'd42};
    mode     = 2'd0;
    dp_mask  = 4'b0000;
`ifdef SEG_BLINK_EN
    blink_mask = 4'b0000;
`endif
    #1 rst_n = 1'b0;
    #1;
    push("rst_sig", 8'hFF);      pop_check(sig_c);
    push("rst_pos", 8'h0F);      pop_check({4'h0, pos});
    push("rst_busy", 8'h00);     pop_check({7'h0, conv_busy});
    push("rst_tick", 8'h00);     pop_check({7'h0, frame_tick});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push("rel_pos", 8'h0E);      pop_check({4'h0, pos});
    push("rel_busy", 8'h01);     pop_check({7'h0, conv_busy});

    // basic numeric frame: sub=42 (field 0), main=7 (field 1)
    check_frame(vals, mode, dp_mask, "num_7_42");

    // frame period
    wait_tick();
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!frame_tick && cnt < 200);
    push("frame_period", 8'(80)); pop_check(8'(cnt));

    // converter busy time after a frame_tick
    wait_tick();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (conv_busy) cnt++;
    end
    push("busy_cycles", 8'(18)); pop_check(8'(cnt));

    // saturation and zero / leading-zero handling
    vals = {7'd120, 7'd42};
    check_frame(vals, 2'd0, 4'b0000, "sat_120");
    vals = {7'd0, 7'd5};
    check_frame(vals, 2'd0, 4'b0000, "zero_5");
    vals = {7'd99, 7'd100};
    check_frame(vals, 2'd0, 4'b0000, "edge_99_100");

    // mid-frame change: current frame keeps the snapshot, next frame updates
    vals = {7'd7, 7'd42};
    wait_tick();
    vals = {7'd7, 7'd42};
    check_frame(vals, 2'd0, 4'b0000, "pre_snap");
    k = 0;
    while (k < 20) begin @(negedge clk); k++; end
    vals = {7'd7, 7'd13};
    while (k < 2 + SC + SC/2) begin @(negedge clk); k++; end
    push("midframe_d1_old", exp_sig({7'd7, 7'd42}, 1, 2'd0, 4'b0000));
    pop_check(sig_c);
    check_frame(vals, 2'd0, 4'b0000, "post_13");

    // display modes
    vals = {7'd7, 7'd42};
    mode = 2'd2; dp_mask = 4'b0001;
    check_frame(vals, mode, dp_mask, "dash_dp");
    mode = 2'd3; dp_mask = 4'b0000;
    check_frame(vals, mode, dp_mask, "lamp");
    mode = 2'd1;
    check_frame(vals, mode, dp_mask, "blank");
    mode = 2'd0; dp_mask = 4'b1010;
    check_frame(vals, mode, dp_mask, "num_dp");
    dp_mask = 4'b0000;

    // asynchronous reset in the middle of SHIFT and mid-digit
    wait_tick();
    repeat (4) @(negedge clk);
    push("pre_rst_sig", exp_sig(vals, 0, 2'd0, 4'b0000)); pop_check(sig_c);
    #2 rst_n = 1'b0;
    #1;
    push("arst_sig", 8'hFF);     pop_check(sig_c);
    push("arst_pos", 8'h0F);     pop_check({4'h0, pos});
    push("arst_busy", 8'h00);    pop_check({7'h0, conv_busy});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push("arel_pos", 8'h0E);     pop_check({4'h0, pos});
    check_frame(vals, 2'd0, 4'b0000, "after_rst");

`ifdef SEG_BLINK_EN
    rst_n = 1'b0;
    blink_mask = 4'b0010;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      wait_tick();
      k = 0;
      while (k < 2 + SC/2) begin @(negedge clk); k++; end
      push($sformatf("blink_f%0d_d0", n), exp_sig(vals, 0, 2'd0, 4'b0000));
      pop_check(sig_c);
      while (k < 2 + SC + SC/2) begin @(negedge clk); k++; end
      push($sformatf("blink_f%0d_d1", n),
           (n == 2 || n == 3) ? 8'hFF : exp_sig(vals, 1, 2'd0, 4'b0000));
      pop_check(sig_c);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
